csr_file_rmw: RTL and testbench

- Parametrised successor to the single-port CSR interface. Executes all six Zicsr operations (CSRRW/S/C, CSRRWI/SI/CI) as an atomic two-phase read-modify-write behind a valid/ready handshake.
- Owns NUM_SCRATCH generic R/W CSRs plus 64-bit mcycle/minstret counters and their user read-only shadows.
- Flags illegal accesses.
- Sits between the decode/execute stage and writeback. The returned old CSR value goes to rd.

---
 rtl/csr_file_rmw.sv | 180 ++++++++++++++++++
 tb/tb_csr_file_rmw.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_file_rmw.sv
// Zicsr CSR file: scratch CSRs plus 64-bit mcycle/minstret, each request run as an atomic read-modify-write.
// Latency: rsp_valid is high in the second cycle after the accept edge; at most one request per 3 cycles.
// Backpressure: req_ready is high only in IDLE while not halted; halt freezes the FSM, so no response is issued.
//
// Ports:
//   clk, rst_n        clock; asynchronous reset, asserted HIGH despite the name
//   halt, retire      freeze FSM and mcycle / count one retired instruction
//   req_*             request handshake plus funct3, CSR address, rs1 index (uimm) and rs1 data
//   rsp_*             one-cycle response: old CSR value (zero if illegal) and illegal flag
module csr_file_rmw #(
  parameter int          XLEN         = 32,
  parameter int          NUM_SCRATCH  = 4,
  parameter logic [11:0] SCRATCH_BASE = 12'h340
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            halt,
  input  logic            retire,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [11:0]     req_addr,
  input  logic [4:0]      req_rs1_idx,
  input  logic [XLEN-1:0] req_rs1_data,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_illegal
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  logic [1:0]      r_state;
  logic [2:0]      r_funct3;
  logic [11:0]     r_addr;
  logic [4:0]      r_rs1_idx;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_old;
  logic            r_illegal;

  logic [XLEN-1:0] r_scratch [NUM_SCRATCH];
  logic [63:0]     r_mcycle;
  logic [63:0]     r_minstret;

  logic [11:0]     w_off;
  logic            w_scr_hit;
  logic            w_ctr_page;
  logic            w_ctr;
  logic            w_ctr_hi;
  logic            w_ctr_ret;
  logic            w_we;
  logic            w_illegal;
  logic            w_commit;
  logic [XLEN-1:0] w_rd_data;
  logic [XLEN-1:0] w_src;
  logic [XLEN-1:0] w_new;

  // ---------------- address decode (on the latched address) ----------------
  // Addresses below the base wrap to large offsets and miss.
  assign w_off      = r_addr - SCRATCH_BASE;
  assign w_scr_hit  = (w_off < 12'(NUM_SCRATCH));
  // Counter CSRs live at B00/B02/B80/B82 and their shadows at C00/C02/C80/C82.
  assign w_ctr_page = (r_addr[11:8] == 4'hB) || (r_addr[11:8] == 4'hC);
  assign w_ctr      = w_ctr_page && ((r_addr[6:0] == 7'h00) || (r_addr[6:0] == 7'h02));
  assign w_ctr_hi   = r_addr[7];
  assign w_ctr_ret  = r_addr[1];

  // RW/RWI always write; set/clear forms write only with a nonzero rs1 index / uimm.
  assign w_we = (r_funct3[1:0] == 2'b01) || (r_rs1_idx != 5'd0);

  assign w_illegal = !(w_scr_hit || w_ctr)
                  || ((r_addr[11:10] == 2'b11) && w_we)
                  || (r_funct3[1:0] == 2'b00)
                  || (w_ctr && w_ctr_hi && (XLEN != 32));

  always_comb begin
    w_rd_data = '0;
    if (w_scr_hit) begin
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (w_off == 12'(i)) w_rd_data = r_scratch[i];
      end
    end else if (w_ctr) begin
      case ({w_ctr_hi, w_ctr_ret})
        2'b00:   w_rd_data = r_mcycle[XLEN-1:0];
        2'b01:   w_rd_data = r_minstret[XLEN-1:0];
        2'b10:   w_rd_data = XLEN'(r_mcycle[63:32]);
        default: w_rd_data = XLEN'(r_minstret[63:32]);
      endcase
    end
  end

  // ---------------- modify ----------------
  assign w_src = r_funct3[2] ? XLEN'(r_rs1_idx) : r_rs1_data;

  always_comb begin
    case (r_funct3[1:0])
      2'b10:   w_new = r_old | w_src;
      2'b11:   w_new = r_old & ~w_src;
      default: w_new = w_src;
    endcase
  end

  assign w_commit = (r_state == S_WRITE) && !halt && w_we && !r_illegal;

  // ---------------- FSM and request latches ----------------
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state    <= S_IDLE;
      r_funct3   <= '0;
      r_addr     <= '0;
      r_rs1_idx  <= '0;
      r_rs1_data <= '0;
      r_old      <= '0;
      r_illegal  <= 1'b0;
    end else if (!halt) begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_funct3   <= req_funct3;
            r_addr     <= req_addr;
            r_rs1_idx  <= req_rs1_idx;
            r_rs1_data <= req_rs1_data;
            r_state    <= S_READ;
          end
        end
        S_READ: begin
          // Counters are sampled before this cycle's increment lands.
          r_old     <= w_rd_data;
          r_illegal <= w_illegal;
          r_state   <= S_WRITE;
        end
        S_WRITE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // ---------------- scratch registers ----------------
  for (genvar g = 0; g < NUM_SCRATCH; g++) begin : g_scr
    always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n)                                      r_scratch[g] <= '0;
      else if (w_commit && w_scr_hit && (w_off == 12'(g))) r_scratch[g] <= w_new;
    end
  end

  // ---------------- counters ----------------
  // A CSR write to either half replaces that cycle's increment outright:
  // the written half takes the value as-is and the other half is untouched.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_mcycle <= '0;
    end else if (w_commit && w_ctr && !w_ctr_ret) begin
      if (w_ctr_hi)          r_mcycle[63:32] <= w_new[31:0];
      else if (XLEN == 64)   r_mcycle        <= 64'(w_new);
      else                   r_mcycle[31:0]  <= w_new[31:0];
    end else if (!halt) begin
      r_mcycle <= r_mcycle + 64'd1;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_minstret <= '0;
    end else if (w_commit && w_ctr && w_ctr_ret) begin
      if (w_ctr_hi)          r_minstret[63:32] <= w_new[31:0];
      else if (XLEN == 64)   r_minstret        <= 64'(w_new);
      else                   r_minstret[31:0]  <= w_new[31:0];
    end else if (retire) begin
      r_minstret <= r_minstret + 64'd1;
    end
  end

  // ---------------- outputs ----------------
  assign req_ready   = (r_state == S_IDLE) && !halt;
  assign rsp_valid   = (r_state == S_WRITE) && !halt;
  assign rsp_rdata   = (rsp_valid && !r_illegal) ? r_old : '0;
  assign rsp_illegal = rsp_valid && r_illegal;

endmodule

// File: tb/tb_csr_file_rmw.sv
// Self-checking bench for csr_file_rmw (XLEN=32, 4 scratch registers at 0x340).
// Expected responses are queued when a request is driven and popped when rsp_valid appears.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_csr_file_rmw;

  localparam logic [2:0] F_RW  = 3'b001;
  localparam logic [2:0] F_RS  = 3'b010;
  localparam logic [2:0] F_RC  = 3'b011;
  localparam logic [2:0] F_RWI = 3'b101;
  localparam logic [2:0] F_RSI = 3'b110;
  localparam logic [2:0] F_RCI = 3'b111;

  typedef struct {
    logic [2:0]  f3;
    logic [11:0] a;
    logic [4:0]  idx;
    logic [31:0] d;
    logic [31:0] r;
    logic        il;
    bit          chk;
  } op_t;

  typedef struct {
    logic [31:0] rdata;
    logic        ill;
    bit          chk;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        halt = 1'b0;
  logic        retire = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_funct3 = '0;
  logic [11:0] req_addr = '0;
  logic [4:0]  req_rs1_idx = '0;
  logic [31:0] req_rs1_data = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_illegal;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  csr_file_rmw #(.XLEN(32), .NUM_SCRATCH(4), .SCRATCH_BASE(12'h340)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .halt         (halt),
    .retire       (retire),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_rs1_idx  (req_rs1_idx),
    .req_rs1_data (req_rs1_data),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_illegal  (rsp_illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Drive one request for a single cycle once the block is ready; returns at the
  // falling edge of the READ cycle.
  task automatic send(input logic [2:0] f3, input logic [11:0] a,
                      input logic [4:0] idx, input logic [31:0] d);
    int w;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    req_valid    = 1'b1;
    req_funct3   = f3;
    req_addr     = a;
    req_rs1_idx  = idx;
    req_rs1_data = d;
    @(negedge clk);
    req_valid    = 1'b0;
  endtask

  // Wait (bounded) for a response; n = falling edges waited after send returned.
  task automatic collect(output logic [31:0] rd, output logic il, output int n, output bit got);
    got = 0;
    n   = 0;
    rd  = '0;
    il  = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (rsp_valid) begin
        got = 1;
        rd  = rsp_rdata;
        il  = rsp_illegal;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (req_ready !== 1'b1)   begin bad++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
    total++; if (rsp_valid !== 1'b0)   begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    total++; if (rsp_rdata !== 32'h0)  begin bad++; $display("FAIL reset_rsp_rdata got=%h want=0", rsp_rdata); end
    total++; if (rsp_illegal !== 1'b0) begin bad++; $display("FAIL reset_rsp_illegal got=%b want=0", rsp_illegal); end
  endtask

  task automatic test_rw_rs();
    op_t ops[$];
    logic [31:0] rd; logic il; int n; bit got; exp_t e;
    ops.push_back('{F_RW, 12'h340, 5'd1, 32'hDEADBEEF, 32'h0,        1'b0, 1'b1});
    ops.push_back('{F_RS, 12'h340, 5'd0, 32'hFFFFFFFF, 32'hDEADBEEF, 1'b0, 1'b1});
    ops.push_back('{F_RS, 12'h340, 5'd0, 32'h0,        32'hDEADBEEF, 1'b0, 1'b1});
    ops.push_back('{F_RW, 12'h342, 5'd1, 32'h12345678, 32'h0,        1'b0, 1'b1});
    ops.push_back('{F_RC, 12'h342, 5'd3, 32'h0000FFFF, 32'h12345678, 1'b0, 1'b1});
    ops.push_back('{F_RS, 12'h342, 5'd0, 32'h0,        32'h12340000, 1'b0, 1'b1});
    for (int i = 0; i < ops.size(); i++) begin
      sb.push_back('{ops[i].r, ops[i].il, ops[i].chk});
      send(ops[i].f3, ops[i].a, ops[i].idx, ops[i].d);
      collect(rd, il, n, got);
      e = sb.pop_front();
      total++;
      if (!got || n != 1 || il !== e.ill || (e.chk && rd !== e.rdata)) begin
        bad++;
        $display("FAIL rw_rs[%0d] got=%0b lat=%0d rdata=%h ill=%b want lat=2 rdata=%h ill=%b",
                 i, got, n + 1, rd, il, e.rdata, e.ill);
      end
    end
  endtask

  task automatic test_imm();
    op_t ops[$];
    logic [31:0] rd; logic il; int n; bit got; exp_t e;
    ops.push_back('{F_RW,  12'h341, 5'd1,  32'hFF00FF00, 32'h0,        1'b0, 1'b1});
    ops.push_back('{F_RCI, 12'h341, 5'h0F, 32'h0,        32'hFF00FF00, 1'b0, 1'b1});
    ops.push_back('{F_RS,  12'h341, 5'd0,  32'h0,        32'hFF00FF00, 1'b0, 1'b1});
    ops.push_back('{F_RSI, 12'h341, 5'h1F, 32'h0,        32'hFF00FF00, 1'b0, 1'b1});
    ops.push_back('{F_RS,  12'h341, 5'd0,  32'h0,        32'hFF00FF1F, 1'b0, 1'b1});
    ops.push_back('{F_RSI, 12'h341, 5'd0,  32'hFFFFFFFF, 32'hFF00FF1F, 1'b0, 1'b1});
    ops.push_back('{F_RC,  12'h341, 5'd0,  32'hFFFFFFFF, 32'hFF00FF1F, 1'b0, 1'b1});
    ops.push_back('{F_RCI, 12'h341, 5'h1F, 32'h0,        32'hFF00FF1F, 1'b0, 1'b1});
    ops.push_back('{F_RS,  12'h341, 5'd0,  32'h0,        32'hFF00FF00, 1'b0, 1'b1});
    ops.push_back('{F_RWI, 12'h343, 5'd5,  32'hFFFFFFFF, 32'h0,        1'b0, 1'b1});
    ops.push_back('{F_RW,  12'h343, 5'd0,  32'h0000ABCD, 32'h5,        1'b0, 1'b1});
    ops.push_back('{F_RS,  12'h343, 5'd0,  32'h0,        32'h0000ABCD, 1'b0, 1'b1});
    for (int i = 0; i < ops.size(); i++) begin
      sb.push_back('{ops[i].r, ops[i].il, ops[i].chk});
      send(ops[i].f3, ops[i].a, ops[i].idx, ops[i].d);
      collect(rd, il, n, got);
      e = sb.pop_front();
      total++;
      if (!got || n != 1 || il !== e.ill || (e.chk && rd !== e.rdata)) begin
        bad++;
        $display("FAIL imm[%0d] got=%0b lat=%0d rdata=%h ill=%b want lat=2 rdata=%h ill=%b",
                 i, got, n + 1, rd, il, e.rdata, e.ill);
      end
    end
  endtask

  task automatic test_illegal();
    op_t ops[$];
    logic [31:0] rd; logic il; int n; bit got; exp_t e;
    ops.push_back('{F_RW,   12'hC00, 5'd1, 32'h0,  32'h0,        1'b1, 1'b1});
    ops.push_back('{F_RW,   12'hC02, 5'd1, 32'h77, 32'h0,        1'b1, 1'b1});
    ops.push_back('{F_RS,   12'hC02, 5'd0, 32'h0,  32'h0,        1'b0, 1'b1});
    ops.push_back('{F_RW,   12'h7FF, 5'd1, 32'h1,  32'h0,        1'b1, 1'b1});
    ops.push_back('{3'b100, 12'h340, 5'd1, 32'h1,  32'h0,        1'b1, 1'b1});
    ops.push_back('{3'b000, 12'h340, 5'd1, 32'h1,  32'h0,        1'b1, 1'b1});
    ops.push_back('{F_RW,   12'h344, 5'd1, 32'h1,  32'h0,        1'b1, 1'b1});
    ops.push_back('{F_RS,   12'h340, 5'd0, 32'h0,  32'hDEADBEEF, 1'b0, 1'b1});
    ops.push_back('{F_RSI,  12'hC00, 5'd1, 32'h0,  32'h0,        1'b1, 1'b1});
    ops.push_back('{F_RS,   12'hC00, 5'd1, 32'h0,  32'h0,        1'b1, 1'b1});
    ops.push_back('{F_RCI,  12'hC02, 5'd0, 32'h0,  32'h0,        1'b0, 1'b1});
    for (int i = 0; i < ops.size(); i++) begin
      sb.push_back('{ops[i].r, ops[i].il, ops[i].chk});
      send(ops[i].f3, ops[i].a, ops[i].idx, ops[i].d);
      collect(rd, il, n, got);
      e = sb.pop_front();
      total++;
      if (!got || n != 1 || il !== e.ill || (e.chk && rd !== e.rdata)) begin
        bad++;
        $display("FAIL illegal[%0d] got=%0b lat=%0d rdata=%h ill=%b want lat=2 rdata=%h ill=%b",
                 i, got, n + 1, rd, il, e.rdata, e.ill);
      end
    end
  endtask

  // Low-half write of all-ones, then back-to-back reads: the first read samples
  // after exactly one increment, so the carry has moved into the upper half.
  task automatic test_counter_carry();
    op_t ops[$];
    logic [31:0] rd; logic il; int n; bit got; exp_t e;
    ops.push_back('{F_RW, 12'hB80, 5'd1, 32'h0,        32'h0,  1'b0, 1'b1});
    ops.push_back('{F_RW, 12'hB00, 5'd1, 32'hFFFFFFFF, 32'h0,  1'b0, 1'b0});
    ops.push_back('{F_RS, 12'hC00, 5'd0, 32'h0,        32'h0,  1'b0, 1'b1});
    ops.push_back('{F_RS, 12'hC80, 5'd0, 32'h0,        32'h1,  1'b0, 1'b1});
    ops.push_back('{F_RW, 12'hB02, 5'd1, 32'h55,       32'h0,  1'b0, 1'b1});
    ops.push_back('{F_RS, 12'hC02, 5'd0, 32'h0,        32'h55, 1'b0, 1'b1});
    ops.push_back('{F_RW, 12'hB82, 5'd1, 32'h7,        32'h0,  1'b0, 1'b1});
    ops.push_back('{F_RS, 12'hC82, 5'd0, 32'h0,        32'h7,  1'b0, 1'b1});
    ops.push_back('{F_RW, 12'hB82, 5'd1, 32'h0,        32'h7,  1'b0, 1'b1});
    ops.push_back('{F_RW, 12'hB02, 5'd1, 32'h0,        32'h55, 1'b0, 1'b1});
    ops.push_back('{F_RS, 12'hB02, 5'd0, 32'h0,        32'h0,  1'b0, 1'b1});
    for (int i = 0; i < ops.size(); i++) begin
      sb.push_back('{ops[i].r, ops[i].il, ops[i].chk});
      send(ops[i].f3, ops[i].a, ops[i].idx, ops[i].d);
      collect(rd, il, n, got);
      e = sb.pop_front();
      total++;
      if (!got || n != 1 || il !== e.ill || (e.chk && rd !== e.rdata)) begin
        bad++;
        $display("FAIL counter[%0d] got=%0b lat=%0d rdata=%h ill=%b want lat=2 rdata=%h ill=%b",
                 i, got, n + 1, rd, il, e.rdata, e.ill);
      end
    end
  endtask

  // Reads mcycle twice back to back, halting the second in READ for 5 cycles
  // with retire held: mcycle advances only over the 3 unhalted cycles between the
  // two samples, and minstret gains exactly 5.
  task automatic test_halt();
    logic [31:0] rd1, rd2; logic il; int n; bit got; bit seen; exp_t e;
    sb.push_back('{32'h0, 1'b0, 1'b0});
    send(F_RS, 12'hC00, 5'd0, 32'h0);
    collect(rd1, il, n, got);
    e = sb.pop_front();
    total++;
    if (!got || n != 1 || il !== e.ill) begin
      bad++; $display("FAIL halt_first got=%0b lat=%0d ill=%b want lat=2 ill=0", got, n + 1, il);
    end

    sb.push_back('{rd1 + 32'd3, 1'b0, 1'b1});
    send(F_RS, 12'hC00, 5'd0, 32'h0);
    halt = 1'b1; retire = 1'b1; seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    halt = 1'b0; retire = 1'b0;
    total++;
    if (seen) begin bad++; $display("FAIL halt_no_rsp got rsp_valid=1 while halted want 0"); end
    collect(rd2, il, n, got);
    e = sb.pop_front();
    total++;
    if (!got || n != 1 || il !== e.ill || rd2 !== e.rdata) begin
      bad++;
      $display("FAIL halt_mcycle got=%0b release_lat=%0d rdata=%h ill=%b want release_lat=1 rdata=%h ill=0",
               got, n, rd2, il, e.rdata);
    end

    sb.push_back('{32'h5, 1'b0, 1'b1});
    send(F_RS, 12'hC02, 5'd0, 32'h0);
    collect(rd2, il, n, got);
    e = sb.pop_front();
    total++;
    if (!got || n != 1 || il !== e.ill || rd2 !== e.rdata) begin
      bad++; $display("FAIL halt_minstret got=%0b lat=%0d rdata=%h want rdata=%h", got, n + 1, rd2, e.rdata);
    end
  endtask

  // Request inputs left asserted during READ/WRITE must not start a new operation.
  task automatic test_back_to_back();
    logic [31:0] rd; logic il; int n; bit got; exp_t e; logic rdy_busy;
    sb.push_back('{32'h12340000, 1'b0, 1'b1});
    send(F_RS, 12'h342, 5'd0, 32'h0);
    rdy_busy     = req_ready;
    req_valid    = 1'b1;
    req_funct3   = F_RW;
    req_addr     = 12'h342;
    req_rs1_idx  = 5'd1;
    req_rs1_data = 32'hFFFFFFFF;
    collect(rd, il, n, got);
    req_valid = 1'b0;
    e = sb.pop_front();
    total++;
    if (rdy_busy !== 1'b0) begin bad++; $display("FAIL b2b_ready_busy got=%b want 0", rdy_busy); end
    total++;
    if (!got || n != 1 || il !== e.ill || rd !== e.rdata) begin
      bad++; $display("FAIL b2b_first got=%0b lat=%0d rdata=%h want lat=2 rdata=%h", got, n + 1, rd, e.rdata);
    end
    sb.push_back('{32'h12340000, 1'b0, 1'b1});
    send(F_RS, 12'h342, 5'd0, 32'h0);
    collect(rd, il, n, got);
    e = sb.pop_front();
    total++;
    if (!got || n != 1 || rd !== e.rdata) begin
      bad++; $display("FAIL b2b_ignored got=%0b lat=%0d rdata=%h want lat=2 rdata=%h", got, n + 1, rd, e.rdata);
    end
  endtask

  task automatic test_reset_mid();
    op_t ops[$];
    logic [31:0] rd; logic il; int n; bit got; bit seen; exp_t e;
    send(F_RW, 12'h341, 5'd1, 32'hA5A5A5A5);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL rst_mid_outputs rsp_valid=%b req_ready=%b want 0 and 1", rsp_valid, req_ready);
    end
    rst_n = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    total++;
    if (seen) begin bad++; $display("FAIL rst_mid_dropped got rsp_valid=1 want no response"); end
    ops.push_back('{F_RS, 12'h341, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1});
    ops.push_back('{F_RS, 12'h340, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1});
    ops.push_back('{F_RS, 12'h343, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1});
    ops.push_back('{F_RS, 12'hC02, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1});
    ops.push_back('{F_RS, 12'hC80, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1});
    for (int i = 0; i < ops.size(); i++) begin
      sb.push_back('{ops[i].r, ops[i].il, ops[i].chk});
      send(ops[i].f3, ops[i].a, ops[i].idx, ops[i].d);
      collect(rd, il, n, got);
      e = sb.pop_front();
      total++;
      if (!got || n != 1 || il !== e.ill || (e.chk && rd !== e.rdata)) begin
        bad++;
        $display("FAIL rst_mid_read[%0d] got=%0b lat=%0d rdata=%h ill=%b want lat=2 rdata=%h ill=%b",
                 i, got, n + 1, rd, il, e.rdata, e.ill);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rw_rs();
    test_imm();
    test_illegal();
    test_counter_carry();
    test_halt();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
